// File: rtl/crc32_arbiter.sv
// crc32_arbiter
// Shares one CRC-32 datapath (IEEE 802.3, reflected, init/xorout 0xFFFFFFFF)
// between NREQ requesters.
//
// Each requester streams 32-bit words with a last flag. Messages are granted
// round-robin and hashed at one word per cycle. Each message yields one
// result, which is tagged with the owning requester's id.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester word valid            [NREQ]
//   req_data   requester i drives [32*i +: 32]      [32*NREQ]
//   req_last   word is the last of its message      [NREQ]
//   req_ready  word accepted when valid & ready     [NREQ]
//   res_valid  result available
//   res_ready  consumer accepts the result
//   res_crc    final CRC (after final XOR)          [32]
//   res_id     requester that owned the message     [IDW]
//   res_words  accepted word count, saturating      [16]
//   res_err    message aborted by owner stall timeout
module crc32_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 0,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_crc,
  output logic [IDW-1:0]       res_id,
  output logic [15:0]          res_words,
  output logic                 res_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // One word through the reflected CRC-32. The word is XORed in whole,
  // because LSB-first processing of a little-endian word equals hashing
  // its 4 bytes in order.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] x;
    x = c ^ w;
    for (int i = 0; i < 32; i++) begin
      if (x[0]) begin
        x = (x >> 1) ^ 32'hEDB8_8320;
      end else begin
        x = x >> 1;
      end
    end
    return x;
  endfunction

  // Pick the first valid at or after the pointer, wrapping. The loop runs
  // downward so that the smallest offset is written last and wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    logic [IDW-1:0] pick;
    int idx;
    pick = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NREQ;
      if (v[idx]) begin
        pick = IDW'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  state_t          state_r, state_s;
  logic [IDW-1:0]  owner_r, owner_s;
  logic [IDW-1:0]  ptr_r, ptr_s;
  logic [31:0]     crc_r, crc_s;
  logic [15:0]     words_r, words_s;
  logic            err_r, err_s;
  logic [31:0]     stall_r, stall_s;
  logic [31:0]     own_word_s;
  logic [IDW-1:0]  grant_s;

  assign own_word_s = req_data[{owner_r, 5'd0} +: 32];
  assign grant_s    = rr_pick(req_valid, ptr_r);

  // Next-state and datapath update for the grant / stream / result sequence.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    crc_s   = crc_r;
    words_s = words_r;
    err_s   = err_r;
    stall_s = stall_r;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          owner_s = grant_s;
          ptr_s   = (int'(grant_s) == NREQ - 1) ? '0 : grant_s + IDW'(1);
          stall_s = 32'd0;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (req_valid[owner_r]) begin
          crc_s   = crc_step(crc_r, own_word_s);
          words_s = (words_r == 16'hFFFF) ? words_r : words_r + 16'd1;
          stall_s = 32'd0;
          if (req_last[owner_r]) begin
            state_s = RESULT;
          end else begin
            state_s = BUSY;
          end
        end else if (TIMEOUT > 0) begin
          // Owner idle: abort once the stall run reaches TIMEOUT cycles.
          if (stall_r + 32'd1 >= 32'(TIMEOUT)) begin
            err_s   = 1'b1;
            state_s = RESULT;
          end else begin
            stall_s = stall_r + 32'd1;
          end
        end else begin
          state_s = BUSY;
        end
      end
      RESULT: begin
        if (res_ready) begin
          crc_s   = 32'hFFFF_FFFF;
          words_s = 16'd0;
          err_s   = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = RESULT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      crc_r   <= 32'hFFFF_FFFF;
      words_r <= 16'd0;
      err_r   <= 1'b0;
      stall_r <= 32'd0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      crc_r   <= crc_s;
      words_r <= words_s;
      err_r   <= err_s;
      stall_r <= stall_s;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= '0;
      res_valid <= 1'b0;
      res_crc   <= 32'd0;
      res_id    <= '0;
      res_words <= 16'd0;
      res_err   <= 1'b0;
    end else begin
      req_ready <= (state_s == BUSY) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_s) : '0;
      res_valid <= (state_s == RESULT);
      res_crc   <= ~crc_s;
      res_id    <= owner_s;
      res_words <= words_s;
      res_err   <= err_s;
    end
  end

endmodule
